// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic datapath blocks
// (multiplier / divider widths and divider FSM encoding).
package arith_pkg;

   localparam int ARITH_DW = 8;
   localparam int ARITH_VW = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, restore on borrow.
module div_step #(
   parameter int VW = 4
) (
   input  logic [VW:0]   pr,
   input  logic          dbit,
   input  logic [VW-1:0] divisor,
   output logic [VW:0]   pr_nx,
   output logic          qbit
);

   logic [VW+1:0] t;
   logic [VW+1:0] d;
   logic [VW+1:0] diff;

   // pr < divisor always holds, so the top bit of t stays 0
   always_comb begin
      t     = {pr, dbit};
      d     = {2'b00, divisor};
      diff  = t - d;
      qbit  = (t >= d);
      pr_nx = qbit ? diff[VW:0] : t[VW:0];
   end

endmodule

// File: rtl/div_8by4_seq.sv
// Sequential restoring divider, one quotient bit per clock,
// with a bypass for divide-by-zero and dividend < divisor.
module div_8by4_seq
   import arith_pkg::*;
#(
   parameter int DW = ARITH_DW,
   parameter int VW = ARITH_VW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quo,
   output logic [VW-1:0] rem,
   output logic          div_zero
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [DW-1:0] dvd;
   logic [VW-1:0] dvs;
   logic [VW:0]   pr;
   logic [DW-1:0] q;
   logic [VW:0]   pr_nx;
   logic          qbit;

   div_step #(.VW(VW)) u_step (
      .pr      (pr),
      .dbit    (dvd[cnt]),
      .divisor (dvs),
      .pr_nx   (pr_nx),
      .qbit    (qbit)
   );

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   // FSM, iteration counter, operand and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         pr       <= '0;
         q        <= '0;
         quo      <= '0;
         rem      <= '0;
         div_zero <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  dvd <= dividend;
                  dvs <= divisor;
                  pr  <= '0;
                  q   <= '0;
                  cnt <= CW'(DW - 1);
                  if (divisor == '0) begin
                     quo      <= '1;
                     rem      <= '0;
                     div_zero <= 1'b1;
                     state    <= S_DONE;
                  end else if (dividend < DW'(divisor)) begin
                     quo      <= '0;
                     rem      <= dividend[VW-1:0];
                     div_zero <= 1'b0;
                     state    <= S_DONE;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               pr <= pr_nx;
               q  <= {q[DW-2:0], qbit};
               if (cnt == '0) begin
                  quo      <= {q[DW-2:0], qbit};
                  rem      <= pr_nx[VW-1:0];
                  div_zero <= 1'b0;
                  state    <= S_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_8by4_seq.sv
// Directed + exhaustive bench for div_8by4_seq,
// scoreboard of expected results checked on out_valid.
module tb_div_8by4_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] quo;
   logic [3:0] rem;
   logic       div_zero;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   div_8by4_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quo       (quo),
      .rem       (rem),
      .div_zero  (div_zero)
   );

   function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
      exp_t e;
      if (b == 4'd0) begin
         e.q = 8'hFF; e.r = 4'd0; e.z = 1'b1;
      end else begin
         e.q = 8'(a / b); e.r = 4'(a % b); e.z = 1'b0;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present operands and hold until the accept edge
   task automatic accept(input logic [7:0] a, input logic [3:0] b);
      int n = 0;
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      chk("accept_timeout", 32'(n < 50), 1);
      step();
      in_valid = 1'b0;
      dividend = 8'hA5;
      divisor  = 4'hC;
   endtask

   // wait for result, apply backpressure, compare, handshake
   task automatic collect(input int exp_lat, input int stall,
                          input bit chk_busy);
      int   lat = 1;
      exp_t e;
      logic [7:0] q0;
      logic [3:0] r0;
      while (!out_valid && lat < 50) begin
         if (chk_busy) chk("busy_in_ready", 32'(in_ready), 0);
         step();
         lat++;
      end
      chk("out_timeout", 32'(out_valid), 1);
      if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
      if (chk_busy) chk("done_in_ready", 32'(in_ready), 0);
      q0 = quo;
      r0 = rem;
      for (int i = 0; i < stall; i++) begin
         step();
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_quo", 32'(quo), 32'(q0));
         chk("hold_rem", 32'(rem), 32'(r0));
      end
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("quo", 32'(quo), 32'(e.q));
         chk("rem", 32'(rem), 32'(e.r));
         chk("div_zero", 32'(div_zero), 32'(e.z));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (chk_busy) begin
         chk("post_valid", 32'(out_valid), 0);
         chk("post_in_ready", 32'(in_ready), 1);
      end
   endtask

   task automatic op(input logic [7:0] a, input logic [3:0] b,
                     input int exp_lat, input int stall,
                     input bit chk_busy);
      sb.push_back(model(a, b));
      accept(a, b);
      collect(exp_lat, stall, chk_busy);
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      step();
      step();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_quo", 32'(quo), 0);
      chk("rst_rem", 32'(rem), 0);
      chk("rst_div_zero", 32'(div_zero), 0);
      rst = 1'b0;
      step();

      op(8'd225, 4'd15, 9, 0, 1'b1);
      op(8'd60, 4'd7, 9, 0, 1'b1);
      op(8'd54, 4'd6, 9, 0, 1'b1);
      op(8'd3, 4'd9, 1, 0, 1'b1);
      op(8'd200, 4'd0, 1, 0, 1'b1);
      op(8'd0, 4'd5, 1, 0, 1'b1);
      op(8'd255, 4'd1, 9, 5, 1'b1);
      op(8'd15, 4'd15, 9, 0, 1'b1);

      // reset in the 4th CALC cycle drops the operation
      accept(8'd120, 4'd8);
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_valid", 32'(out_valid), 0);
      chk("rst_mid_in_ready", 32'(in_ready), 1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen++;
      end
      chk("rst_mid_no_out", 32'(seen), 0);
      op(8'd120, 4'd8, 9, 0, 1'b1);

      // full operand sweep against the reference model
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            op(8'(a), 4'(b), 0, 0, 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
